jt1942_objpxl: RTL and testbench

- Object line buffer directly downstream of the object draw stage.
- Takes the (posx, new_pxl) pixel stream produced during line N and stores it in a 256-entry buffer.
- Replays that buffer in screen order during line N+1 as obj_pxl, which feeds the colour mixer.
- Double-buffered (two banks swapped every line); each entry is erased as it is read.

---
 rtl/jt1942_objpxl.sv | 100 ++++++++++
 tb/tb_jt1942_objpxl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/jt1942_objpxl.sv
// Double-buffered object line buffer: captures one line of object pixels from
// the draw stage and replays them in screen order on the next line.
module jt1942_objpxl #(
  parameter int         LINEW = 8,
  parameter logic [3:0] BLANK = 4'hF
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       cen6,
  input  logic       flip,
  input  logic [8:0] H,
  input  logic       HINIT,
  input  logic       LHBL,
  input  logic [8:0] posx,
  input  logic [3:0] new_pxl,
  output logic [3:0] obj_pxl
);

  localparam int DEPTH = 2**LINEW;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t           state, state_nxt;
  logic [LINEW-1:0] cnt;
  logic             lnsel;

  logic [3:0] bank0 [DEPTH];
  logic [3:0] bank1 [DEPTH];

  logic [LINEW-1:0] raddr, waddr;
  logic [3:0]       rdata, wcur;
  logic             wr_ok;

  logic             we0, we1;
  logic [LINEW-1:0] a0, a1;
  logic [3:0]       d0, d1;

  logic unused_h;
  assign unused_h = ^H[8:LINEW];

  assign raddr = H[LINEW-1:0] ^ {LINEW{flip}};
  assign waddr = posx[LINEW-1:0];
  assign rdata = lnsel ? bank0[raddr] : bank1[raddr];
  assign wcur  = lnsel ? bank1[waddr] : bank0[waddr];
  // First opaque pixel at an address wins; the draw stage emits in priority order.
  assign wr_ok = ~posx[8] && (new_pxl != BLANK) && (wcur == BLANK);

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_nxt = state;
    we0 = 1'b0;  a0 = cnt;  d0 = BLANK;
    we1 = 1'b0;  a1 = cnt;  d1 = BLANK;
    case (state)
      CLEAR: begin
        we0 = 1'b1;
        we1 = 1'b1;
        if (cnt == '1) state_nxt = RUN;
      end
      RUN: begin
        if (cen6) begin
          // The read bank is erased behind the readout, the other bank takes pixels.
          if (lnsel) begin
            we0 = 1'b1;   a0 = raddr;  d0 = BLANK;
            we1 = wr_ok;  a1 = waddr;  d1 = new_pxl;
          end else begin
            we1 = 1'b1;   a1 = raddr;  d1 = BLANK;
            we0 = wr_ok;  a0 = waddr;  d0 = new_pxl;
          end
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  // NOTE: the line RAMs have no reset; the CLEAR sweep initialises them instead.
  always_ff @(posedge clk) begin
    if (we0) bank0[a0] <= d0;
    if (we1) bank1[a1] <= d1;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state   <= CLEAR;
      cnt     <= '0;
      lnsel   <= 1'b0;
      obj_pxl <= BLANK;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) begin
        cnt     <= cnt + 1'b1;
        obj_pxl <= BLANK;
      end else if (cen6) begin
        obj_pxl <= LHBL ? rdata : BLANK;
      end
      if (cen6 && HINIT) lnsel <= ~lnsel;
    end
  end

endmodule

// File: tb/tb_jt1942_objpxl.sv
// Directed bench for jt1942_objpxl with a two-bank reference model and a
// scoreboard queue of expected obj_pxl values.
module tb_jt1942_objpxl;

  localparam logic [3:0] BLANK = 4'hF;

  logic       rst, clk, cen6, flip, HINIT, LHBL;
  logic [8:0] H, posx;
  logic [3:0] new_pxl, obj_pxl;

  jt1942_objpxl #(.LINEW(8), .BLANK(BLANK)) dut (
    .rst(rst), .clk(clk), .cen6(cen6), .flip(flip), .H(H), .HINIT(HINIT),
    .LHBL(LHBL), .posx(posx), .new_pxl(new_pxl), .obj_pxl(obj_pxl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] pos;
    logic [3:0] val;
  } wr_t;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] mb [2][256];
  bit         ml;
  bit         m_run;
  logic [3:0] exp_q [$];
  wr_t        wq [$];
  logic [3:0] got [256];
  logic [3:0] last_pxl;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_wipe();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 256; i++) mb[b][i] = BLANK;
  endtask

  // One cen6 strobe, then an idle clk with junk inputs to prove everything holds.
  task automatic step(input logic hi, input logic lh, input logic fl,
                      input logic [8:0] h, input logic [8:0] px, input logic [3:0] np);
    logic [7:0] ra;
    logic [3:0] e;
    @(negedge clk);
    HINIT = hi; LHBL = lh; flip = fl; H = h; posx = px; new_pxl = np; cen6 = 1'b1;
    ra = h[7:0] ^ {8{fl}};
    e  = BLANK;
    if (m_run) begin
      e = lh ? mb[~ml][ra] : BLANK;
      if (!px[8] && np != BLANK && mb[ml][px[7:0]] == BLANK) mb[ml][px[7:0]] = np;
      mb[~ml][ra] = BLANK;
    end
    if (hi) ml = ~ml;
    exp_q.push_back(e);
    @(negedge clk);
    cen6 = 1'b0; HINIT = 1'b0;
    H = 9'($urandom); LHBL = 1'($urandom);
    posx = {1'b0, 8'($urandom)}; new_pxl = 4'($urandom_range(0, 14));
    e = exp_q.pop_front();
    last_pxl = obj_pxl;
    check("pxl", obj_pxl, e);
    @(negedge clk);
    check("hold", obj_pxl, e);
  endtask

  task automatic line(input logic lh, input logic fl, input int nsteps);
    logic [8:0] px;
    logic [3:0] np;
    for (int k = 0; k < nsteps; k++) begin
      px = 9'h1FF;
      np = BLANK;
      if (wq.size() > 0) begin
        px = wq[0].pos;
        np = wq[0].val;
        void'(wq.pop_front());
      end
      step(k == 255, lh, fl, 9'(k), px, np);
      got[k] = last_pxl;
    end
  endtask

  initial begin
    rst = 1'b1; cen6 = 1'b0; flip = 1'b0; HINIT = 1'b0; LHBL = 1'b1;
    H = '0; posx = 9'h1FF; new_pxl = BLANK;
    ml = 1'b0; m_run = 1'b0;
    model_wipe();
    repeat (3) @(negedge clk);
    check("reset", obj_pxl, BLANK);

    // CLEAR sweep with cen6 held high, opaque writes offered and one HINIT.
    rst = 1'b0; cen6 = 1'b1; LHBL = 1'b1;
    for (int i = 0; i < 256; i++) begin
      H = 9'(i); HINIT = (i == 10); posx = 9'h010; new_pxl = 4'h3;
      if (i == 10) ml = ~ml;
      @(negedge clk);
      check("clear_pxl", obj_pxl, BLANK);
    end
    cen6 = 1'b0; HINIT = 1'b0;
    m_run = 1'b1;

    // Both banks read back blank; second line loads the write-rule cases.
    line(1'b1, 1'b0, 256);
    wq.push_back('{9'h010, 4'h3});
    wq.push_back('{9'h020, 4'h5});
    wq.push_back('{9'h020, 4'h9});
    wq.push_back('{9'h030, 4'hF});
    wq.push_back('{9'h030, 4'h9});
    wq.push_back('{9'h100, 4'h2});
    wq.push_back('{9'h1FF, 4'h1});
    line(1'b1, 1'b0, 256);

    wq.push_back('{9'h020, 4'h7});
    line(1'b1, 1'b0, 256);
    check("px10", got[8'h10], 4'h3);
    check("first_wins", got[8'h20], 4'h5);
    check("after_blank", got[8'h30], 4'h9);
    check("drop_100", got[8'h00], BLANK);
    check("drop_1ff", got[8'hFF], BLANK);
    check("neighbour", got[8'h11], BLANK);

    wq.push_back('{9'h040, 4'h6});
    line(1'b1, 1'b1, 256);
    check("flip_df", got[8'hDF], 4'h7);
    check("flip_20", got[8'h20], BLANK);

    line(1'b0, 1'b0, 256);
    check("lhbl_40", got[8'h40], BLANK);
    line(1'b1, 1'b0, 256);
    wq.push_back('{9'h005, 4'hA});
    line(1'b1, 1'b0, 256);
    check("blank_cleared", got[8'h40], BLANK);

    line(1'b1, 1'b0, 6);
    check("pre_rst", got[5], 4'hA);

    // Reset mid-line, then again mid-sweep; the restart must reach 256 clocks.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid", obj_pxl, BLANK);
    ml = 1'b0; m_run = 1'b0;
    model_wipe();
    rst = 1'b0;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (199) @(negedge clk);
    step(1'b0, 1'b1, 1'b0, 9'h030, 9'h030, 4'h4);
    repeat (60) @(negedge clk);
    m_run = 1'b1;

    line(1'b1, 1'b0, 256);
    line(1'b1, 1'b0, 256);
    check("clear_restart", got[8'h30], BLANK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout observed running expected finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
